// File: rtl/imm_extend_stage_pkg.sv
// Shared constants for the immediate-extension stage: mode encodings and widths.
package imm_extend_stage_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] EXT_SIGN   = 2'b00;
  localparam logic [MODE_W-1:0] EXT_ZERO   = 2'b01;
  localparam logic [MODE_W-1:0] EXT_UPPER  = 2'b10;
  localparam logic [MODE_W-1:0] EXT_BRANCH = 2'b11;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extender: raw immediate + mode -> OUT_WIDTH result.
module imm_extend_core
  import imm_extend_stage_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic [IN_WIDTH-1:0]  imm,
  input  logic [MODE_W-1:0]    mode,
  output logic [OUT_WIDTH-1:0] data
);

  localparam int E = OUT_WIDTH - IN_WIDTH;

  // Branch mode needs two spare bits above the immediate for the <<2.
  if (IN_WIDTH < 2) begin : g_bad_in_width
    $error("imm_extend_core: IN_WIDTH must be >= 2");
  end
  if (OUT_WIDTH < IN_WIDTH + 2) begin : g_bad_out_width
    $error("imm_extend_core: OUT_WIDTH must be >= IN_WIDTH+2");
  end

  logic [OUT_WIDTH-1:0] sign_ext;
  logic [OUT_WIDTH-1:0] zero_ext;
  logic [OUT_WIDTH-1:0] upper_ext;
  logic [OUT_WIDTH-1:0] branch_ext;

  assign sign_ext   = {{E{imm[IN_WIDTH-1]}}, imm};
  assign zero_ext   = {{E{1'b0}}, imm};
  assign upper_ext  = {imm, {E{1'b0}}};
  // Word-offset to byte-offset: top two sign bits fall off the end.
  assign branch_ext = {sign_ext[OUT_WIDTH-3:0], 2'b00};

  // Select the extension flavour for the requested mode.
  always_comb begin
    data = sign_ext;
    case (mode)
      EXT_SIGN:   data = sign_ext;
      EXT_ZERO:   data = zero_ext;
      EXT_UPPER:  data = upper_ext;
      EXT_BRANCH: data = branch_ext;
      default:    data = sign_ext;
    endcase
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage with valid/ready on both sides.
// A main entry drives the output; a skid entry absorbs one extra beat so that
// in_ready depends only on registered state and never on out_ready.
module imm_extend_stage
  import imm_extend_stage_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_imm,
  input  logic [MODE_W-1:0]    in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data
);

  logic                 main_valid;
  logic [OUT_WIDTH-1:0] main_data;
  logic                 skid_valid;
  logic [OUT_WIDTH-1:0] skid_data;
  logic [OUT_WIDTH-1:0] ext_data;
  logic                 accept;
  logic                 xfer;

  // Extension happens on the way in; only extended data is stored.
  imm_extend_core #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_core (
    .imm  (in_imm),
    .mode (in_mode),
    .data (ext_data)
  );

  assign in_ready  = !skid_valid && !rst;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  // Flush wins over a same-cycle accept, so the beat is dropped.
  assign accept = in_valid && in_ready && !flush;
  assign xfer   = main_valid && out_ready;

  // Main/skid occupancy update; strict FIFO order between the two entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      // Data registers keep their contents; only occupancy is cleared.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || xfer) begin
      if (skid_valid) begin
        // Older skid beat moves up; in_ready was 0 so nothing new arrives.
        main_valid <= 1'b1;
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_data  <= ext_data;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      // Main stalled: park the new beat in the skid entry.
      skid_valid <= 1'b1;
      skid_data  <= ext_data;
    end
  end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Self-checking bench for imm_extend_stage (IN_WIDTH=16, OUT_WIDTH=32).
// Reference model: a FIFO of extended values holding at most two entries,
// with extension computed by plain integer arithmetic.
module tb_imm_extend_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] q[$];
  logic [31:0] last_out;
  logic        cur_rst;

  imm_extend_stage #(
    .IN_WIDTH  (16),
    .OUT_WIDTH (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    longint s;
    longint t;
    s = longint'(imm);
    if (imm >= 16'h8000) s = s - 65536;
    case (mode)
      2'd0:    t = s;
      2'd1:    t = longint'(imm);
      2'd2:    t = longint'(imm) * 65536;
      default: t = s * 4;
    endcase
    return t[31:0];
  endfunction

  // Apply one cycle of inputs, advance the model across the edge, and
  // return 1 time unit after the edge with the same inputs still applied.
  task automatic step(input logic iv, input logic [15:0] imm, input logic [1:0] md,
                      input logic ordy, input logic fl, input logic r);
    bit mready;
    bit mxfer;
    bit macc;
    rst = r; flush = fl; in_valid = iv; in_imm = imm; in_mode = md; out_ready = ordy;
    mready = (q.size() < 2) && !r;
    mxfer  = (q.size() > 0) && ordy;
    macc   = iv && mready && !fl;
    if (r) begin
      q.delete();
      last_out = 32'h0;
    end else if (fl) begin
      q.delete();
    end else begin
      if (mxfer) void'(q.pop_front());
      if (macc) q.push_back(ref_ext(imm, md));
      if (q.size() > 0) last_out = q[0];
    end
    cur_rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(0, 16'h0, 2'd0, 1, 0, 1);
    step(0, 16'h0, 2'd0, 1, 0, 1);
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== 32'h0) $display("FAIL reset_out_data got %h exp 00000000", out_data);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready_during got %b exp 0", in_ready);
    else pass_cnt++;
    step(0, 16'h0, 2'd0, 1, 0, 0);
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready_after got %b exp 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_modes();
    logic [15:0] imms [5] = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF, 16'h7FFF};
    logic [1:0]  mds  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    logic [31:0] exps [5] = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFFFC, 32'h0001FFFC};
    for (int i = 0; i < 5; i++) begin
      step(1, imms[i], mds[i], 1, 0, 0);
      total_cnt++;
      if (out_valid !== 1'b1 || out_data !== exps[i])
        $display("FAIL mode_vec%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, exps[i]);
      else pass_cnt++;
      step(0, 16'h0, 2'd0, 1, 0, 0);
    end
    // Random immediates in every mode against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] im;
      logic [1:0]  md;
      im = 16'($urandom);
      md = 2'($urandom_range(0, 3));
      step(1, im, md, 1, 0, 0);
      total_cnt++;
      if (out_valid !== 1'b1 || out_data !== ref_ext(im, md))
        $display("FAIL mode_rand imm=%h mode=%0d got v=%b d=%h exp d=%h",
                 im, md, out_valid, out_data, ref_ext(im, md));
      else pass_cnt++;
    end
    step(0, 16'h0, 2'd0, 1, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] im;
    logic [1:0]  md;
    for (int i = 0; i < 8; i++) begin
      im = 16'($urandom);
      md = 2'($urandom_range(0, 3));
      step(1, im, md, 1, 0, 0);
      total_cnt++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== ref_ext(im, md))
        $display("FAIL b2b_beat%0d got r=%b v=%b d=%h exp r=1 v=1 d=%h",
                 i, in_ready, out_valid, out_data, ref_ext(im, md));
      else pass_cnt++;
    end
    step(0, 16'h0, 2'd0, 1, 0, 0);
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL b2b_drain got v=%b exp 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    step(1, 16'h0001, 2'd1, 0, 0, 0);
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'h1)
      $display("FAIL bp_after_a got r=%b v=%b d=%h exp r=1 v=1 d=00000001", in_ready, out_valid, out_data);
    else pass_cnt++;
    step(1, 16'h0002, 2'd1, 0, 0, 0);
    total_cnt++;
    if (in_ready !== 1'b0 || out_data !== 32'h1)
      $display("FAIL bp_after_b got r=%b d=%h exp r=0 d=00000001", in_ready, out_data);
    else pass_cnt++;
    // in_valid held with a different value: must not be taken while full.
    step(1, 16'h0003, 2'd1, 0, 0, 0);
    total_cnt++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h1)
      $display("FAIL bp_hold got r=%b v=%b d=%h exp r=0 v=1 d=00000001", in_ready, out_valid, out_data);
    else pass_cnt++;
    step(0, 16'h0, 2'd0, 1, 0, 0);
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'h2)
      $display("FAIL bp_emit_b got r=%b v=%b d=%h exp r=1 v=1 d=00000002", in_ready, out_valid, out_data);
    else pass_cnt++;
    step(0, 16'h0, 2'd0, 1, 0, 0);
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL bp_empty got v=%b exp 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    step(1, 16'h00AA, 2'd1, 0, 0, 0);
    step(1, 16'h00BB, 2'd1, 0, 0, 0);
    step(1, 16'h00CC, 2'd1, 0, 1, 0);
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h000000AA)
      $display("FAIL flush_state got v=%b r=%b d=%h exp v=0 r=1 d=000000aa", out_valid, in_ready, out_data);
    else pass_cnt++;
    step(0, 16'h0, 2'd0, 1, 0, 0);
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL flush_no_emit got v=%b exp 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_rst_mid();
    step(1, 16'h1111, 2'd2, 0, 0, 0);
    step(1, 16'h2222, 2'd2, 0, 0, 0);
    step(1, 16'h3333, 2'd2, 1, 0, 1);
    total_cnt++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b0)
      $display("FAIL rstmid_during got v=%b d=%h r=%b exp v=0 d=00000000 r=0", out_valid, out_data, in_ready);
    else pass_cnt++;
    step(0, 16'h0, 2'd0, 1, 0, 0);
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL rstmid_after got r=%b v=%b exp r=1 v=0", in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] exp_d;
    bit          exp_v;
    bit          exp_r;
    int          errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 16'($urandom), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0), ($urandom_range(0, 80) == 0));
      exp_v = (q.size() > 0);
      exp_r = (q.size() < 2) && !cur_rst;
      exp_d = last_out;
      total_cnt++;
      if (out_valid !== exp_v || in_ready !== exp_r || out_data !== exp_d) begin
        errs++;
        if (errs <= 10)
          $display("FAIL random_cyc%0d got v=%b r=%b d=%h exp v=%b r=%b d=%h",
                   i, out_valid, in_ready, out_data, exp_v, exp_r, exp_d);
      end else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b1;
    last_out = 32'h0;
    cur_rst = 1'b1;
    test_reset();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
